// File: rtl/int_ctrl.sv
// Machine-level interrupt controller: edge-captures requests, masks with mie, issues one trap at a time.
// Define ROUND_ROBIN_EN for round-robin source selection; the default is fixed lowest-index priority.
module int_ctrl #(
  parameter int N_INT        = 6,
  parameter int CAUSE_OFFSET = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] int_req,
  input  logic [N_INT-1:0] mie,
  input  logic             int_rst,
  input  logic             mret,
  output logic             int_o,
  output logic             en_mepc,
  output logic [31:0]      mcause,
  output logic [N_INT-1:0] int_fin,
  output logic             busy
);

  localparam int          IDX_W      = (N_INT > 1) ? $clog2(N_INT) : 1;
  localparam logic [30:0] CAUSE_BASE = 31'(CAUSE_OFFSET);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_INT-1:0] req_q, req_d;
  logic [N_INT-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_INT-1:0] eligible;
  logic [N_INT-1:0] fin_vec;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Masking applies only to selection; masked lines keep their pending bit.
  assign eligible = pending_q & mie;

`ifdef ROUND_ROBIN_EN
  always_comb begin : sel_rr
    int j;
    j         = 0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < N_INT; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_INT) j = j - N_INT;
      if (!sel_valid && eligible[j]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end
`else
  always_comb begin : sel_fixed
    sel_idx   = '0;
    sel_valid = 1'b0;
    // Scanning downward lets the lowest eligible index overwrite the rest.
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    fin_vec = '0;
    if (state_q == S_DONE) fin_vec[idx_q] = 1'b1;
  end

  always_comb begin
    req_d     = int_req;
    // A new edge in the same cycle as the ack must survive, so the set term is ORed last.
    pending_d = (pending_q & ~fin_vec) | (int_req & ~req_q);
    state_d   = state_q;
    idx_d     = idx_q;
    mcause_d  = mcause_q;
`ifdef ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!int_rst && sel_valid) begin
          state_d  = S_ISSUE;
          idx_d    = sel_idx;
          mcause_d = {1'b1, CAUSE_BASE + 31'(sel_idx)};
        end
      end
      S_ISSUE:   state_d = S_SERVICE;
      S_SERVICE: if (mret) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ROUND_ROBIN_EN
        rr_ptr_d = (idx_q == IDX_W'(N_INT - 1)) ? '0 : idx_q + 1'b1;
`endif
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous,
  // so it is an ordinary priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      mcause_q  <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      mcause_q  <= mcause_d;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign int_o   = (state_q == S_ISSUE);
  assign en_mepc = (state_q == S_ISSUE);
  assign int_fin = fin_vec;
  assign busy    = (state_q != S_IDLE);
  assign mcause  = mcause_q;

endmodule
